mac_controller: RTL
===================

Name: mac_controller

Overview:
Sequencing controller for the 3x3 MAC datapath: computes a VEC_LEN-element dot product of unsigned 3-bit operand pairs. Instantiates the existing combinational 3-bit `multiplier` internally and feeds it from registered operands. Accumulates each 6-bit product into an ACC_W-bit saturating accumulator and presents the result on a valid/ready output handshake. Sits between the operand source (testbench or upstream FIFO) and the result consumer.

Parameters:
VEC_LEN, 4, number of operand pairs per dot product; legal range 1..15.
ACC_W, 8, accumulator/result width in bits; legal range 6..16. Default covers the worst case 4*49=196.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  synchronous reset, active-low; sampled on the clk rising edge.
start  input  1  one-cycle request to begin a new dot product; honoured only in IDLE.
abort  input  1  synchronous cancel; returns to IDLE from any state.
in_valid  input  1  operand pair valid.
in_a  input  3  operand a, unsigned.
in_b  input  3  operand b, unsigned.
in_ready  output  1  controller can accept an operand pair.
res_valid  output  1  result valid.
res_ready  input  1  consumer accepts the result.
result  output  ACC_W  accumulated dot product.
ovf  output  1  sticky saturation flag for the current/last dot product.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge), from any state and mid-operation: state=IDLE, acc=0, count=0, operand regs=0, ovf=0. All outputs low/zero: in_ready, res_valid, busy, result.
- States: IDLE, RUN, MUL, DONE.
- IDLE: in_ready=0, busy=0. On start=1: acc<=0, count<=0, ovf<=0, next state RUN. result holds the last value until the next start.
- RUN: in_ready=1. On in_valid&&in_ready: in_a/in_b are registered into op_a/op_b; next state MUL. With in_valid=0, stays in RUN indefinitely.
- MUL: in_ready=0. p = op_a*op_b (6 bits, from the multiplier instance). Sum = acc + zero-extended p, computed at ACC_W+1 bits.
  - If the sum exceeds 2^ACC_W-1: acc<=all-ones and ovf<=1.
  - Otherwise acc<=sum.
  - count<=count+1.
  - Next state: DONE if count+1==VEC_LEN, else RUN.
- Throughput: one operand pair per 2 cycles.
- DONE: res_valid=1, result=acc; both stay stable while res_ready=0. On res_ready=1: res_valid drops the next cycle and the state returns to IDLE.
- Latency: the result is valid in the cycle after the edge that performs the last MUL update. That is 2 edges after the last input handshake.
- ovf: sticky from the saturating update until the next accepted start or reset. Once saturated, acc stays at all-ones.
- start outside IDLE is ignored, with no effect on acc or count.
- abort=1 in any non-IDLE state: next state IDLE. acc, count and ovf are retained, not cleared. res_valid=0 from the next cycle.
- Priority when signals coincide: rst_n over abort over start/handshake.
- start and abort both high in IDLE: abort wins, stay IDLE.
- in_valid is ignored whenever in_ready=0; operands presented then are never captured.
- count width: clog2(VEC_LEN+1). count never exceeds VEC_LEN.
- The multiplier is purely combinational; op_a/op_b stay stable through MUL, so the product is valid within that cycle.

Test Plan:
- Defaults, start, then pairs (3,5),(2,6),(0,7),(1,1) back-to-back -> res_valid=1 one cycle after the 4th MUL, result=28, ovf=0, return to IDLE after res_ready.
- Defaults, four (7,7) pairs -> result=196 (max fits), ovf=0. Then start again with (1,1)x4 -> result=4, ovf=0 (acc cleared).
- ACC_W=7, four (7,7) pairs -> partial sums 49, 98, then saturate at 127, ovf=1 from the 3rd MUL; result=127. Next start clears ovf.
- Gaps and backpressure: in_valid toggled 1/0 randomly and pairs held stable; values presented while in_ready=0 are ignored -> only handshaked pairs counted. Hold res_ready=0 for 5 cycles in DONE -> result and res_valid stable, busy=1.
- Reset mid-run: rst_n=0 in MUL after 2 pairs -> next cycle IDLE with all outputs 0. A fresh dot product of (2,3)x4 gives 24.
- start pulsed in RUN/MUL/DONE -> no effect. abort in RUN after 1 pair -> IDLE, busy=0, res_valid never asserted; abort and start together in IDLE -> stays IDLE.

Source files
------------

// File: rtl/mac_controller.sv
// mac_controller: sequences VEC_LEN operand pairs through a 3x3 multiplier into a saturating accumulator.
// Rev 1.0
`default_nettype none

module multiplier (
   input  logic [2:0] a_i,
   input  logic [2:0] b_i,
   output logic [5:0] p_o
);
   logic [5:0] w_pp0;
   logic [5:0] w_pp1;
   logic [5:0] w_pp2;

   assign w_pp0 = {3'b000, a_i}       & {6{b_i[0]}};
   assign w_pp1 = {2'b00, a_i, 1'b0}  & {6{b_i[1]}};
   assign w_pp2 = {1'b0, a_i, 2'b00}  & {6{b_i[2]}};
   assign p_o   = w_pp0 + w_pp1 + w_pp2;
endmodule

module mac_controller #(
   parameter int VEC_LEN = 4,
   parameter int ACC_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             in_valid,
   input  logic [2:0]       in_a,
   input  logic [2:0]       in_b,
   output logic             in_ready,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [ACC_W-1:0] result,
   output logic             ovf,
   output logic             busy
);
   localparam int CNT_W = $clog2(VEC_LEN + 1);
   localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(VEC_LEN);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_MUL  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [2:0]       op_a_q, op_a_d;
   logic [2:0]       op_b_q, op_b_d;
   logic             ovf_q, ovf_d;

   logic [5:0]       w_prod;
   logic [ACC_W:0]   w_sum;
   logic [CNT_W-1:0] w_count_inc;

   multiplier u_mult (
      .a_i (op_a_q),
      .b_i (op_b_q),
      .p_o (w_prod)
   );

   // One spare bit on the sum exposes overflow of the ACC_W-bit accumulator.
   assign w_sum       = {1'b0, acc_q} + {{(ACC_W - 5){1'b0}}, w_prod};
   assign w_count_inc = count_q + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         count_q <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      count_d   = count_q;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      ovf_d     = ovf_q;
      in_ready  = 1'b0;
      res_valid = 1'b0;
      busy      = 1'b1;

      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (!abort && start) begin
               acc_d   = '0;
               count_d = '0;
               ovf_d   = 1'b0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            in_ready = 1'b1;
            if (abort) begin
               state_d = S_IDLE;
            end else if (in_valid) begin
               op_a_d  = in_a;
               op_b_d  = in_b;
               state_d = S_MUL;
            end
         end
         S_MUL: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               if (w_sum[ACC_W]) begin
                  acc_d = '1;
                  ovf_d = 1'b1;
               end else begin
                  acc_d = w_sum[ACC_W-1:0];
               end
               count_d = w_count_inc;
               state_d = (w_count_inc == C_LAST_CNT) ? S_DONE : S_RUN;
            end
         end
         S_DONE: begin
            res_valid = 1'b1;
            if (abort || res_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign result = acc_q;
   assign ovf    = ovf_q;
endmodule

`default_nettype wire
